// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder
//   Unified instruction/data memory slave for the multicycle CPU bus. Takes one
//   word request at a time over a valid/ready handshake, inserts wait states,
//   then returns a one-cycle response pulse (read data and error flag).
//   A request accepted at edge t0 responds from edge t0+LATENCY to t0+LATENCY+1.
//
//   Parameters
//     DEPTH_LOG2  log2 of memory depth in 32-bit words
//     LATENCY     cycles from acceptance to response, legal range 1..15
//
//   Ports
//     clk         rising-edge clock
//     reset       synchronous, active-high reset
//     req_valid   request present
//     req_write   1 = store, 0 = load/fetch
//     req_addr    byte address (aliases modulo the memory size)
//     req_wdata   store data
//     req_ready   idle and able to accept
//     resp_valid  one-cycle response pulse
//     resp_rdata  registered read data, holds until the next read response
//     resp_err    access error, qualified by resp_valid
//     busy        request in flight
//
//   Optional build macro
//     MULTICYCLE_MEM_MISALIGN_CHECK_EN  flag requests with req_addr[1:0] != 0
//                                       as errors; no write, no read update.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | counting wait states down to zero
//   RESP  | access performed on entry; pulse follows on the exit edge

module multicycle_mem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("multicycle_mem_responder: LATENCY must be in 1..15");
  end

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  wr_q;
  logic [31:0]           wdata_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  mis_q;
  logic                  accept;
  logic                  enter_resp;
  logic                  mis_in;
  logic                  acc_wr;
  logic                  acc_mis;
  logic [31:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [31:0]           mem [0:DEPTH-1];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

`ifdef MULTICYCLE_MEM_MISALIGN_CHECK_EN
  logic unused_addr;
  assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];
  assign mis_in      = (req_addr[1:0] != 2'b00);
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  assign mis_in      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RESP is never held, so a next state of RESP always marks the entry edge.
  assign enter_resp = (state_nxt == RESP);

  // With LATENCY=1 the access edge is the acceptance edge itself, so the
  // request fields are taken straight from the bus in that case.
  assign acc_wr    = (state == IDLE) ? req_write                   : wr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata                   : wdata_q;
  assign acc_idx   = (state == IDLE) ? req_addr[DEPTH_LOG2+1:2]    : idx_q;
  assign acc_mis   = (state == IDLE) ? mis_in                      : mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'd0;
      idx_q      <= '0;
      mis_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      resp_valid <= (state == RESP);
      resp_err   <= (state == RESP) & mis_q;
      if (accept) begin
        wr_q    <= req_write;
        wdata_q <= req_wdata;
        idx_q   <= req_addr[DEPTH_LOG2+1:2];
        mis_q   <= mis_in;
      end
      if (enter_resp && !acc_wr && !acc_mis) resp_rdata <= mem[acc_idx];
    end
  end

  // Array has no reset; reset only blocks a commit that has not happened yet.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_wr && !acc_mis) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
module tb_multicycle_mem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  // u[0]: LATENCY=2, u[1]: LATENCY=1, u[2]: LATENCY=4
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [31:0] last_rd  = 32'd0;
    int          last_acc = 0;
    int          n_resp   = 0;
    exp_t        expq[$];

    multicycle_mem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy)
    );

    always @(negedge clk) begin
      if (!reset) begin
        if (resp_valid) begin
          n_resp++;
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp dut%0d cyc=%0d rdata=%h err=%b", g, cyc, resp_rdata, resp_err);
          end else begin
            exp_t e;
            e = expq.pop_front();
            if (resp_rdata !== e.rdata || resp_err !== e.err || cyc != e.due) begin
              errors++;
              $display("FAIL resp dut%0d got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                       g, resp_rdata, resp_err, cyc, e.rdata, e.err, e.due);
            end
          end
        end else if (expq.size() > 0 && cyc > expq[0].due) begin
          checks++;
          errors++;
          $display("FAIL missing_resp dut%0d cyc=%0d due=%0d", g, cyc, expq[0].due);
          void'(expq.pop_front());
        end
      end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit hold, input bit push);
      exp_t e;
      logic err;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      for (int n = 0; n < 40 && !req_ready; n++) @(negedge clk);
      if (!req_ready) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout dut%0d got=0 expected=1", g);
        req_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      last_acc = cyc;
`ifdef MULTICYCLE_MEM_MISALIGN_CHECK_EN
      err = (addr[1:0] != 2'b00);
`else
      err = 1'b0;
`endif
      if (!wr && !err) last_rd = exp_rd;
      e.rdata = last_rd;
      e.err   = err;
      e.due   = cyc + LAT;
      if (push) expq.push_back(e);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
      for (int n = 0; n < 40 && expq.size() > 0; n++) @(negedge clk);
      check($sformatf("drain_dut%0d", g), expq.size(), 0);
    endtask

    task automatic chk_idle(input string tag);
      check($sformatf("%s_ready_dut%0d", tag, g), req_ready, 1);
      check($sformatf("%s_valid_dut%0d", tag, g), resp_valid, 0);
      check($sformatf("%s_busy_dut%0d", tag, g), busy, 0);
      check($sformatf("%s_err_dut%0d", tag, g), resp_err, 0);
    endtask
  end

  int t_a;
  int nr;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    u[0].chk_idle("reset");
    u[1].chk_idle("reset");
    u[2].chk_idle("reset");
    check("reset_rdata_dut0", u[0].resp_rdata, 32'd0);
    check("reset_rdata_dut1", u[1].resp_rdata, 32'd0);
    check("reset_rdata_dut2", u[2].resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // LATENCY=2 write then read, spacing LATENCY+1
    u[0].req(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    t_a = u[0].last_acc;
    u[0].req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    check("lat2_spacing", u[0].last_acc - t_a, 3);
    u[0].drain();

    // Aliasing: 0x104 and 0x004 hit the same word
    u[0].req(1'b1, 32'h104, 32'h12345678, 32'h0, 1'b0, 1'b1);
    u[0].req(1'b0, 32'h004, 32'h0, 32'h12345678, 1'b0, 1'b1);
    u[0].drain();

    // Misaligned write
    u[0].req(1'b1, 32'h20, 32'h00000005, 32'h0, 1'b0, 1'b1);
    u[0].req(1'b1, 32'h22, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
`ifdef MULTICYCLE_MEM_MISALIGN_CHECK_EN
    u[0].req(1'b0, 32'h20, 32'h0, 32'h00000005, 1'b0, 1'b1);
`else
    u[0].req(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
`endif
    u[0].drain();

    // LATENCY=1 back-to-back reads with req_valid held high
    u[1].req(1'b1, 32'h0, 32'hA0A0A0A0, 32'h0, 1'b0, 1'b1);
    u[1].req(1'b1, 32'h4, 32'hB1B1B1B1, 32'h0, 1'b0, 1'b1);
    u[1].drain();
    u[1].req(1'b0, 32'h0, 32'h0, 32'hA0A0A0A0, 1'b1, 1'b1);
    t_a = u[1].last_acc;
    u[1].req(1'b0, 32'h4, 32'h0, 32'hB1B1B1B1, 1'b0, 1'b1);
    check("lat1_spacing", u[1].last_acc - t_a, 2);
    u[1].drain();

    // LATENCY=4: reset during WAIT of a write discards it
    u[2].req(1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b1);
    u[2].drain();
    u[2].req(1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    u[0].last_rd = 32'd0;
    u[1].last_rd = 32'd0;
    u[2].last_rd = 32'd0;
    nr = u[2].n_resp;
    repeat (8) @(negedge clk);
    check("rst_no_resp", u[2].n_resp, nr);
    u[2].chk_idle("after_rst");
    check("after_rst_rdata", u[2].resp_rdata, 32'd0);
    u[2].req(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b1);
    u[2].drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
